// File: rtl/vfat_link_monitor.sv
// Per-VFAT link status monitor behind the frame aligner: lock FSM,
// loss/instability counters, time-to-lock and windowed S-bit occupancy.
module vfat_link_monitor #(
    parameter int MXSBITS         = 64,
    parameter int CNT_WIDTH       = 16,
    parameter int LOCK_TIME_WIDTH = 24,
    parameter int WINDOW_LOG2     = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       reset_cnt,
    input  logic [MXSBITS-1:0]         sbits,
    input  logic                       sot_is_aligned,
    input  logic                       sot_unstable,
    input  logic [CNT_WIDTH-1:0]       hot_threshold,
    output logic [1:0]                 state,
    output logic                       link_good,
    output logic [CNT_WIDTH-1:0]       lock_loss_cnt,
    output logic [CNT_WIDTH-1:0]       unstable_cnt,
    output logic [LOCK_TIME_WIDTH-1:0] lock_time,
    output logic                       lock_time_valid,
    output logic [WINDOW_LOG2:0]       hit_rate,
    output logic                       rate_valid,
    output logic                       hot
);

    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_LOST   = 2'd2;

    localparam int OCCW = WINDOW_LOG2 + 1;
    localparam int CMPW = (CNT_WIDTH > OCCW) ? CNT_WIDTH : OCCW;

    logic [MXSBITS-1:0]         sbits_q;
    logic                       aligned_q;
    logic                       unstable_q;
    logic                       unstable_prev_q;

    logic [1:0]                 state_q, state_d;
    logic [LOCK_TIME_WIDTH-1:0] timer_q, timer_d;
    logic [LOCK_TIME_WIDTH-1:0] lock_time_q, lock_time_d;
    logic                       ltv_q, ltv_d;
    logic                       link_good_q, link_good_d;
    logic [CNT_WIDTH-1:0]       loss_q, loss_d;
    logic [CNT_WIDTH-1:0]       unst_q, unst_d;

    logic [WINDOW_LOG2-1:0]     win_q, win_d;
    logic [OCCW-1:0]            occ_q, occ_d;
    logic [OCCW-1:0]            rate_q, rate_d;
    logic                       rv_q, rv_d;
    logic                       hot_q, hot_d;

    logic                       lock_event;
    logic                       loss_event;
    logic                       unst_rise;
    logic                       hit;
    logic                       win_end;
    logic [OCCW-1:0]            occ_sum;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        lock_event = 1'b0;
        loss_event = 1'b0;
        case (state_q)
            ST_WAIT, ST_LOST: begin
                if (aligned_q) begin
                    state_d    = ST_LOCKED;
                    lock_event = 1'b1;
                    timer_d    = '0;
                end else if (~&timer_q) begin
                    timer_d = timer_q + LOCK_TIME_WIDTH'(1);
                end
            end
            ST_LOCKED: begin
                timer_d = '0;
                if (!aligned_q) begin
                    state_d    = ST_LOST;
                    loss_event = 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT;
                timer_d = '0;
            end
        endcase
    end

    assign lock_time_d = lock_event ? timer_q : lock_time_q;
    assign ltv_d       = ltv_q | lock_event;
    assign link_good_d = (state_q == ST_LOCKED) && !unstable_q;
    assign unst_rise   = unstable_q && !unstable_prev_q;

    always_comb begin
        loss_d = loss_q;
        unst_d = unst_q;
        if (reset_cnt) begin
            loss_d = '0;
            unst_d = '0;
        end else begin
            if (loss_event && ~&loss_q) loss_d = loss_q + CNT_WIDTH'(1);
            if (unst_rise && ~&unst_q)  unst_d = unst_q + CNT_WIDTH'(1);
        end
    end

    // Window total includes the final cycle's hit, so a full window reads 2^N.
    assign hit     = (state_q == ST_LOCKED) && (|sbits_q);
    assign win_end = &win_q;
    assign occ_sum = occ_q + OCCW'(hit);

    always_comb begin
        win_d  = win_q + WINDOW_LOG2'(1);
        occ_d  = occ_sum;
        rate_d = rate_q;
        hot_d  = hot_q;
        rv_d   = 1'b0;
        if (reset_cnt) begin
            win_d  = '0;
            occ_d  = '0;
            rate_d = '0;
            hot_d  = 1'b0;
        end else if (win_end) begin
            occ_d  = '0;
            rate_d = occ_sum;
            hot_d  = CMPW'(occ_sum) > CMPW'(hot_threshold);
            rv_d   = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sbits_q         <= '0;
            aligned_q       <= 1'b0;
            unstable_q      <= 1'b0;
            unstable_prev_q <= 1'b0;
            state_q         <= ST_WAIT;
            timer_q         <= '0;
            lock_time_q     <= '0;
            ltv_q           <= 1'b0;
            link_good_q     <= 1'b0;
            loss_q          <= '0;
            unst_q          <= '0;
            win_q           <= '0;
            occ_q           <= '0;
            rate_q          <= '0;
            rv_q            <= 1'b0;
            hot_q           <= 1'b0;
        end else begin
            sbits_q         <= sbits;
            aligned_q       <= sot_is_aligned;
            unstable_q      <= sot_unstable;
            unstable_prev_q <= unstable_q;
            state_q         <= state_d;
            timer_q         <= timer_d;
            lock_time_q     <= lock_time_d;
            ltv_q           <= ltv_d;
            link_good_q     <= link_good_d;
            loss_q          <= loss_d;
            unst_q          <= unst_d;
            win_q           <= win_d;
            occ_q           <= occ_d;
            rate_q          <= rate_d;
            rv_q            <= rv_d;
            hot_q           <= hot_d;
        end
    end

    assign state           = state_q;
    assign link_good       = link_good_q;
    assign lock_loss_cnt   = loss_q;
    assign unstable_cnt    = unst_q;
    assign lock_time       = lock_time_q;
    assign lock_time_valid = ltv_q;
    assign hit_rate        = rate_q;
    assign rate_valid      = rv_q;
    assign hot             = hot_q;

endmodule
